// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed 4-digit active-low seven-segment bus and rebuilds the
// displayed hex value, decimal points, per-digit validity and glyph errors.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  input  logic        clr_err,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        err
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [7:0] prev_seg;
  logic [3:0] prev_an;
  logic [7:0] cnt;
  logic [3:0] seen;

  logic       changed;
  logic [7:0] cnt_next;
  logic       commit;
  logic       onehot;
  logic [1:0] idx;
  logic [3:0] seen_next;
  logic       glyph_ok;
  logic [3:0] glyph_val;
  logic       blank;
  logic       illegal;

  always_comb begin
    changed  = ({seg, an} != {prev_seg, prev_an});
    cnt_next = changed ? 8'd1 : ((cnt >= STABLE) ? cnt : cnt + 8'd1);
    // A load edge can itself commit when the threshold is 1; a saturated
    // count that merely stays at the threshold must not commit again.
    commit   = (cnt_next == STABLE) && (changed || (cnt != STABLE));
  end

  always_comb begin
    onehot = 1'b1;
    idx    = 2'd0;
    unique case (an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: onehot = 1'b0;
    endcase
    seen_next = seen | ~an;
  end

  // Decimal point is ignored for matching: force bit 0 to the "off" level.
  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    unique case ({seg[7:1], 1'b1})
      8'h03: glyph_val = 4'h0;
      8'h9F: glyph_val = 4'h1;
      8'h25: glyph_val = 4'h2;
      8'h0D: glyph_val = 4'h3;
      8'h99: glyph_val = 4'h4;
      8'h49: glyph_val = 4'h5;
      8'h41: glyph_val = 4'h6;
      8'h1F: glyph_val = 4'h7;
      8'h01: glyph_val = 4'h8;
      8'h09: glyph_val = 4'h9;
      8'h11: glyph_val = 4'hA;
      8'hC1: glyph_val = 4'hB;
      8'h63: glyph_val = 4'hC;
      8'h85: glyph_val = 4'hD;
      8'h61: glyph_val = 4'hE;
      8'h71: glyph_val = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
    blank   = (seg[7:1] == 7'h7F);
    illegal = commit && onehot && !glyph_ok && !blank;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_seg    <= 8'hFF;
      prev_an     <= 4'hF;
      cnt         <= '0;
      seen        <= '0;
      value       <= '0;
      dp          <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      prev_seg   <= seg;
      prev_an    <= an;
      cnt        <= cnt_next;
      frame_done <= 1'b0;
      if (commit && onehot) begin
        if (glyph_ok) begin
          value[{idx, 2'b00} +: 4] <= glyph_val;
          digit_valid[idx]         <= 1'b1;
          dp[idx]                  <= ~seg[0];
        end else begin
          digit_valid[idx] <= 1'b0;
        end
        if (seen_next == 4'hF) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_next;
        end
      end
      if (illegal)
        err <= 1'b1;
      else if (clr_err)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized and directed checks of seg_scan_decoder against a run-length
// reference model of the scan bus.
module tb_seg_scan_decoder;

  localparam int ST = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        clr_err;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        err;

  seg_scan_decoder #(.STABLE_CYCLES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .clr_err(clr_err),
    .value(value), .dp(dp), .digit_valid(digit_valid),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fd_count = 0;

  logic [7:0] glyph [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                             8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  // Reference state: the last sampled bus pattern and how many consecutive
  // samples it has been seen; a digit commits when that run reaches ST.
  logic [15:0] m_value;
  logic [3:0]  m_dp, m_dv, m_seen;
  logic        m_fd, m_err;
  logic [11:0] m_last;
  int          m_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [7:0] s, input logic [3:0] a,
                            input logic c);
    int zeros;
    int d;
    int k;
    logic [7:0] g;
    logic bad_glyph;
    if (!r) begin
      m_value = '0; m_dp = '0; m_dv = '0; m_seen = '0;
      m_fd = 1'b0; m_err = 1'b0; m_last = 12'hFFF; m_run = 0;
      return;
    end
    m_fd = 1'b0;
    bad_glyph = 1'b0;
    if ({s, a} == m_last) m_run++;
    else begin
      m_last = {s, a};
      m_run  = 1;
    end
    zeros = 0;
    d = 0;
    for (int i = 0; i < 4; i++)
      if (!a[i]) begin zeros++; d = i; end
    if (m_run == ST && zeros == 1) begin
      k = -1;
      for (int j = 0; j < 16; j++) begin
        g = glyph[j];
        if (s[7:1] == g[7:1]) k = j;
      end
      if (k >= 0) begin
        m_value[d*4 +: 4] = 4'(k);
        m_dv[d] = 1'b1;
        m_dp[d] = ~s[0];
      end else begin
        m_dv[d] = 1'b0;
        if (s[7:1] != 7'h7F) bad_glyph = 1'b1;
      end
      m_seen[d] = 1'b1;
      if (m_seen == 4'hF) begin
        m_fd = 1'b1;
        m_seen = '0;
      end
    end
    if (bad_glyph) m_err = 1'b1;
    else if (c) m_err = 1'b0;
  endtask

  task automatic step(input logic r, input logic [7:0] s, input logic [3:0] a, input logic c);
    @(negedge clk);
    rst_n = r; seg = s; an = a; clr_err = c;
    @(posedge clk);
    model_edge(r, s, a, c);
    #1;
    chk("value", 32'(value), 32'(m_value));
    chk("dp", 32'(dp), 32'(m_dp));
    chk("digit_valid", 32'(digit_valid), 32'(m_dv));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("err", 32'(err), 32'(m_err));
    if (frame_done) fd_count++;
  endtask

  task automatic hold(input logic [7:0] s, input logic [3:0] a, input int n);
    for (int i = 0; i < n; i++) step(1'b1, s, a, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'hFF, 4'hF, 1'b0);
    step(1'b0, 8'hFF, 4'hF, 1'b0);
  endtask

  initial begin
    int fd0;
    rst_n = 1'b0; seg = 8'hFF; an = 4'hF; clr_err = 1'b0;
    do_reset();
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // Basic scan 3210
    fd0 = fd_count;
    hold(8'h03, 4'hE, 4);
    hold(8'h9F, 4'hD, 4);
    hold(8'h25, 4'hB, 3);
    chk("scan_no_early_fd", 32'(fd_count - fd0), 32'd0);
    hold(8'h25, 4'hB, 1);
    hold(8'h0D, 4'h7, 3);
    chk("scan_fd_not_yet", 32'(frame_done), 32'd0);
    hold(8'h0D, 4'h7, 1);
    chk("scan_fd", 32'(frame_done), 32'd1);
    chk("scan_value", 32'(value), 32'h3210);
    chk("scan_dv", 32'(digit_valid), 32'hF);
    chk("scan_dp", 32'(dp), 32'h0);
    hold(8'h0D, 4'h7, 3);
    chk("scan_fd_once", 32'(fd_count - fd0), 32'd1);

    // Glitch: A for 3 cycles never commits, then b
    hold(8'h11, 4'hE, 3);
    chk("glitch_hold", 32'(value[3:0]), 32'h0);
    hold(8'hC1, 4'hE, 4);
    chk("glitch_b", 32'(value[3:0]), 32'hB);

    // 8 with dp, illegal, then clear
    hold(8'h00, 4'hB, 4);
    chk("d2_eight", 32'(value[11:8]), 32'h8);
    chk("d2_dp", 32'(dp[2]), 32'h1);
    hold(8'h55, 4'hB, 4);
    chk("ill_dv", 32'(digit_valid[2]), 32'h0);
    chk("ill_hold", 32'(value[11:8]), 32'h8);
    chk("ill_err", 32'(err), 32'h1);
    step(1'b1, 8'h55, 4'hB, 1'b1);
    chk("clr_err", 32'(err), 32'h0);

    // Non-one-hot anodes
    do_reset();
    fd0 = fd_count;
    hold(8'h03, 4'hC, 10);
    hold(8'h9F, 4'hF, 10);
    hold(8'h25, 4'h0, 10);
    chk("multi_an_value", 32'(value), 32'h0);
    chk("multi_an_dv", 32'(digit_valid), 32'h0);
    hold(8'h03, 4'hE, 4);
    hold(8'h03, 4'hD, 4);
    hold(8'h03, 4'hB, 4);
    chk("multi_an_nofd", 32'(fd_count - fd0), 32'd0);

    // Long hold then completion, then lone re-scan
    do_reset();
    fd0 = fd_count;
    hold(8'h99, 4'h7, 20);
    hold(8'h49, 4'hE, 4);
    hold(8'h41, 4'hD, 4);
    hold(8'h1F, 4'hB, 4);
    chk("long_fd", 32'(fd_count - fd0), 32'd1);
    chk("long_value", 32'(value), 32'h4765);
    hold(8'h09, 4'hE, 6);
    hold(8'h09, 4'hF, 2);
    hold(8'h61, 4'hE, 6);
    chk("rescan_nofd", 32'(fd_count - fd0), 32'd1);

    // Mid-frame reset discards partial frame
    hold(8'h71, 4'hD, 4);
    hold(8'h63, 4'hB, 4);
    do_reset();
    chk("mid_rst_value", 32'(value), 32'h0);
    chk("mid_rst_dv", 32'(digit_valid), 32'h0);
    fd0 = fd_count;
    hold(8'h85, 4'hE, 4);
    hold(8'h85, 4'hD, 4);
    hold(8'h85, 4'hB, 4);
    chk("post_rst_nofd", 32'(fd_count - fd0), 32'd0);
    hold(8'h85, 4'h7, 4);
    chk("post_rst_fd", 32'(fd_count - fd0), 32'd1);

    // Randomized scan traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a;
      logic [7:0] s;
      int len;
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) begin
        case ($urandom_range(0, 3))
          0: a = 4'hE;
          1: a = 4'hD;
          2: a = 4'hB;
          default: a = 4'h7;
        endcase
      end else a = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) s = glyph[$urandom_range(0, 15)] & {7'h7F, 1'($urandom)};
      else if (r == 7) s = {7'h7F, 1'($urandom)};
      else s = 8'($urandom);
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++)
        step(1'b1, s, a, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
